// File: rtl/adder_pipe_if.sv
// Handshake bundle for adder_pipe: operation request channel (in_*, a, b, sub)
// and result channel (out_*, sum, ovf) plus the delivered-result counter.
interface adder_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [15:0]      count;

    // Producer/consumer side that drives operations and accepts results
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, ovf, count
    );

    // The pipelined adder itself
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, ovf, count
    );
endinterface

// File: rtl/adder_pipe.sv
// Elastic add/subtract pipeline. The arithmetic is done as the operation
// enters stage 0; later stages only carry {valid, sum, ovf} forward. Each
// stage moves when the stage after it is empty or moving, so bubbles collapse
// and a full pipe with a ready consumer sustains one operation per cycle.
module adder_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    adder_pipe_if.slave  bus
);

    logic [STAGES-1:0] valid_reg;
    logic [WIDTH:0]    sum_reg [STAGES];
    logic              ovf_reg [STAGES];
    logic [15:0]       count_reg;

    logic [STAGES-1:0] adv;        // stage i hands its entry onward this cycle
    logic [STAGES-1:0] room;       // stage i can load a new entry this cycle
    logic [STAGES-1:0] src_valid;  // what stage i would load
    logic [WIDTH:0]    src_sum [STAGES];
    logic              src_ovf [STAGES];

    logic [WIDTH:0]    res_next;
    logic              ovf_next;
    logic              out_xfer;

    // Operation result: WIDTH+1 bit unsigned result plus signed-overflow flag
    always_comb begin
        logic [WIDTH:0] a_ext;
        logic [WIDTH:0] b_ext;
        logic           sign_a;
        logic           sign_b;
        logic           sign_r;
        a_ext    = {1'b0, bus.a};
        b_ext    = {1'b0, bus.b};
        res_next = bus.sub ? (a_ext - b_ext) : (a_ext + b_ext);
        sign_a   = bus.a[WIDTH-1];
        sign_b   = bus.b[WIDTH-1];
        sign_r   = res_next[WIDTH-1];
        // Overflow only possible when the effective operand signs agree
        // (add: equal signs, subtract: opposite signs) and the result flips.
        if (bus.sub) begin
            ovf_next = (sign_a != sign_b) && (sign_r != sign_a);
        end else begin
            ovf_next = (sign_a == sign_b) && (sign_r != sign_a);
        end
    end

    // Advance/room chain, evaluated from the output stage back to stage 0
    always_comb begin
        logic nxt_room;
        adv      = '0;
        room     = '0;
        nxt_room = bus.out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i]   = valid_reg[i] && nxt_room;
            room[i]  = !valid_reg[i] || adv[i];
            nxt_room = room[i];
        end
    end

    // Load source per stage: stage 0 takes the new operation, others their predecessor
    always_comb begin
        src_valid    = '0;
        src_valid[0] = bus.in_valid;
        src_sum[0]   = res_next;
        src_ovf[0]   = ovf_next;
        for (int i = 1; i < STAGES; i++) begin
            src_valid[i] = adv[i-1];
            src_sum[i]   = sum_reg[i-1];
            src_ovf[i]   = ovf_reg[i-1];
        end
    end

    // Stage registers; data only changes when a valid entry is loaded
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= '0;
            for (int i = 0; i < STAGES; i++) begin
                sum_reg[i] <= '0;
                ovf_reg[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (room[i]) begin
                    valid_reg[i] <= src_valid[i];
                    if (src_valid[i]) begin
                        sum_reg[i] <= src_sum[i];
                        ovf_reg[i] <= src_ovf[i];
                    end
                end
            end
        end
    end

    assign out_xfer = valid_reg[STAGES-1] && bus.out_ready;

    // Delivered-result counter, saturating at all ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (out_xfer && (count_reg != 16'hFFFF)) begin
            count_reg <= count_reg + 16'd1;
        end
    end

    assign bus.in_ready  = room[0];
    assign bus.out_valid = valid_reg[STAGES-1];
    assign bus.sum       = sum_reg[STAGES-1];
    assign bus.ovf       = ovf_reg[STAGES-1];
    assign bus.count     = count_reg;

endmodule

// File: tb/tb_adder_pipe.sv
// Randomized bench for adder_pipe (WIDTH=4, STAGES=2) with a queue-based
// reference model checked on every falling edge.
module tb_adder_pipe;
    localparam int W = 4;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    adder_pipe_if #(.WIDTH(W)) bus ();

    adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, want);
        end
    endtask

    // Reference arithmetic straight from the integer definitions
    function automatic void ref_op(input int a, input int b, input bit sub,
                                   output int s, output bit o);
        int sa, sb, r;
        s  = sub ? ((a - b) & ((1 << (W + 1)) - 1)) : (a + b);
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        r  = sub ? sa - sb : sa + sb;
        o  = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    endfunction

    typedef struct {
        int s;
        bit o;
        int acc;
    } item_t;

    item_t q[$];
    int    m_count  = 0;
    int    last_dep = -100;
    bit    armed    = 0;
    bit    just_rst = 0;
    bit    prev_stall = 0;
    logic [W:0] prev_sum;
    logic  prev_ovf;

    // Compare process: model of an elastic S-deep pipe in terms of queue order
    // and earliest availability (accept + S, or one cycle after the previous departure)
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_count    = 0;
            last_dep   = -100;
            armed      = 1;
            just_rst   = 1;
            prev_stall = 0;
        end else if (armed) begin
            bit    exp_ov, exp_ir;
            int    due;
            item_t it;
            exp_ov = 0;
            if (q.size() > 0) begin
                due = q[0].acc + S;
                if (last_dep + 1 > due) due = last_dep + 1;
                exp_ov = (cyc >= due);
            end
            exp_ir = (q.size() < S) || (exp_ov && bus.out_ready);
            chk("out_valid", bus.out_valid, exp_ov);
            chk("in_ready", bus.in_ready, exp_ir);
            chk("count", bus.count, m_count);
            if (just_rst) begin
                chk("sum_after_reset", bus.sum, 0);
                chk("ovf_after_reset", bus.ovf, 0);
            end
            if (exp_ov) begin
                chk("sum", bus.sum, q[0].s);
                chk("ovf", bus.ovf, q[0].o);
            end
            if (prev_stall) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_sum", bus.sum, prev_sum);
                chk("stall_ovf", bus.ovf, prev_ovf);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_sum   = bus.sum;
            prev_ovf   = bus.ovf;
            if (exp_ov && bus.out_ready) begin
                void'(q.pop_front());
                last_dep = cyc;
                if (m_count != 65535) m_count++;
            end
            if (bus.in_valid && exp_ir) begin
                ref_op(int'(bus.a), int'(bus.b), bus.sub, it.s, it.o);
                it.acc = cyc;
                q.push_back(it);
            end
            just_rst = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_op();
        bus.a   = W'($urandom_range(0, (1 << W) - 1));
        bus.b   = W'($urandom_range(0, (1 << W) - 1));
        bus.sub = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Single operation with out_ready high; result must be there two cycles later
    task automatic lit(input int a, input int b, input bit sub, input int es, input bit eo);
        bus.a        = W'(a);
        bus.b        = W'(b);
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        rand_op();
        step();
        @(negedge clk);
        chk("lit_valid", bus.out_valid, 1);
        chk("lit_sum", bus.sum, es);
        chk("lit_ovf", bus.ovf, eo);
        step();
    endtask

    initial begin
        int s, acc;
        bit o;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;
        step();

        // Pin the reference model against hand-computed values
        ref_op(15, 1, 0, s, o); chk("model_15p1", {s, 1'b0} | o, {16, 1'b0});
        ref_op(7, 1, 0, s, o);  chk("model_7p1", {s, 1'b0} | o, {8, 1'b1});
        ref_op(3, 5, 1, s, o);  chk("model_3m5", {s, 1'b0} | o, {30, 1'b0});
        ref_op(8, 1, 1, s, o);  chk("model_8m1", {s, 1'b0} | o, {7, 1'b1});

        // Directed literal results
        lit(15, 1, 0, 16, 0);
        lit(7, 1, 0, 8, 1);
        lit(3, 5, 1, 30, 0);
        lit(8, 1, 1, 7, 1);

        // Back-pressure: consumer stalled for 6 cycles with continuous input
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            rand_op();
            @(negedge clk);
            if (bus.in_ready) acc++;
            step();
        end
        @(negedge clk);
        chk("stall_accepted", acc, 2);
        chk("stall_in_ready", bus.in_ready, 0);
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) step();

        // Full-rate streaming of 20 operations from a clean reset
        do_reset();
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            rand_op();
            @(negedge clk);
            if (bus.in_ready) acc++;
            step();
        end
        bus.in_valid = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("stream_accepted", acc, 20);
        chk("stream_count", bus.count, 20);
        step();

        // Reset with two operations in flight
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        rand_op();
        step();
        rand_op();
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        do_reset();
        @(negedge clk);
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_count", bus.count, 0);
        step();
        repeat (4) step();

        // Random traffic on both handshakes; operands keep moving when idle
        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            rand_op();
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) step();

        // Counter saturation: more than 65535 transfers from reset
        do_reset();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            rand_op();
            step();
        end
        bus.in_valid = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("count_saturated", bus.count, 16'hFFFF);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
